// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port dmem between the CPU (port 0) and a DMA/host loader (port 1).
// Optional macro DMEM_ARB_CNT_EN adds cnt_m0/cnt_m1/cnt_conflict activity counters.
`ifndef DATA_W
`define DATA_W 32
`endif

module dmem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [ADDR_W-1:0]  m0_a,
  input  logic [`DATA_W-1:0] m0_wd,
  output logic               m0_ack,
  output logic [`DATA_W-1:0] m0_rd,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [ADDR_W-1:0]  m1_a,
  input  logic [`DATA_W-1:0] m1_wd,
  output logic               m1_ack,
  output logic [`DATA_W-1:0] m1_rd,
  input  logic               m1_lock,
  output logic [ADDR_W-1:0]  mem_a,
  output logic [`DATA_W-1:0] mem_wd,
  output logic               mem_we,
  input  logic [`DATA_W-1:0] mem_rd,
  output logic               busy
`ifdef DMEM_ARB_CNT_EN
  ,
  output logic [31:0]        cnt_m0,
  output logic [31:0]        cnt_m1,
  output logic [31:0]        cnt_conflict
`endif
);

  localparam int CW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          we_q;
  logic          owner;
  logic          last;
  logic [CW-1:0] lock_cnt;
  logic          both;
  logic          lock_win;
  logic          grant1;

  // Lock only extends a port-1 run that is already in progress (last == 1).
  always_comb begin
    both     = m0_req & m1_req;
    lock_win = m1_lock & last & (lock_cnt < CW'(LOCK_MAX));
    grant1   = m1_req;
    if (both) begin
      grant1 = lock_win | ~last;
    end
  end

  assign mem_we = we_q & (state == ACCESS) & rst_n;
  assign busy   = (state == ACCESS) || (state == RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_a    <= '0;
      mem_wd   <= '0;
      we_q     <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rd    <= '0;
      m1_rd    <= '0;
      last     <= 1'b1;
      lock_cnt <= '0;
      owner    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            mem_a  <= grant1 ? m1_a  : m0_a;
            mem_wd <= grant1 ? m1_wd : m0_wd;
            we_q   <= grant1 ? m1_we : m0_we;
            owner  <= grant1;
            last   <= grant1;
            state  <= ACCESS;
            if (!grant1 || !m1_lock) begin
              lock_cnt <= '0;
            end else if (both && lock_win) begin
              lock_cnt <= lock_cnt + CW'(1);
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (owner) begin
              m1_rd <= mem_rd;
            end else begin
              m0_rd <= mem_rd;
            end
          end
          m0_ack <= ~owner;
          m1_ack <= owner;
          state  <= RESP;
        end
        RESP: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_m0       <= '0;
      cnt_m1       <= '0;
      cnt_conflict <= '0;
    end else begin
      if (m0_ack) begin
        cnt_m0 <= cnt_m0 + 32'd1;
      end
      if (m1_ack) begin
        cnt_m1 <= cnt_m1 + 32'd1;
      end
      if ((state == IDLE) && both) begin
        cnt_conflict <= cnt_conflict + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
`ifndef DATA_W
`define DATA_W 32
`endif

module tb_dmem_arbiter;
  localparam int DW       = `DATA_W;
  localparam int AW       = 16;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack, m1_lock;
  logic [AW-1:0] m0_a, m1_a, mem_a;
  logic [DW-1:0] m0_wd, m0_rd, m1_wd, m1_rd, mem_wd, mem_rd;
  logic          mem_we, busy;
`ifdef DMEM_ARB_CNT_EN
  logic [31:0]   cnt_m0, cnt_m1, cnt_conflict;
`endif

  dmem_arbiter #(.ADDR_W(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_a(m0_a), .m0_wd(m0_wd), .m0_ack(m0_ack), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_a(m1_a), .m1_wd(m1_wd), .m1_ack(m1_ack), .m1_rd(m1_rd),
    .m1_lock(m1_lock), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd), .busy(busy)
`ifdef DMEM_ARB_CNT_EN
    , .cnt_m0(cnt_m0), .cnt_m1(cnt_m1), .cnt_conflict(cnt_conflict)
`endif
  );

  // Small dmem: combinational read, posedge write; pokes preload it while the DUT is in reset.
  logic [DW-1:0] dmem [0:15];
  logic          poke_en = 1'b0;
  logic [3:0]    poke_a = '0;
  logic [DW-1:0] poke_d = '0;
  assign mem_rd = (mem_a < AW'(16)) ? dmem[mem_a[3:0]] : '0;
  always @(posedge clk) begin
    if (mem_we && mem_a < AW'(16)) dmem[mem_a[3:0]] <= mem_wd;
    if (poke_en) dmem[poke_a] <= poke_d;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: one access in flight, granted at an edge, done at the next edge.
  logic [DW-1:0] model_mem [0:15];
  int            cyc = 0;
  int            m_ready = 0;
  bit            m_last = 1'b1;
  int            m_lock = 0;
  bit            acc_valid = 1'b0;
  int            acc_edge = 0;
  bit            acc_port, acc_we;
  logic [AW-1:0] acc_a;
  logic [DW-1:0] acc_wd;
  logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
  bit            exp_ack0, exp_ack1, exp_we, exp_busy;
  logic [AW-1:0] exp_a = '0;
  logic [DW-1:0] exp_wd = '0;
  bit            keep_mode = 1'b0, rand_mode = 1'b0;
  int            ack_port[$];
  int            ack_cyc[$];

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(32'hA500_0000 + i * 32'h0001_0011);
  endfunction

  task automatic model_edge();
    bit both, lock_on, win;
    exp_ack0 = 1'b0;
    exp_ack1 = 1'b0;
    exp_we   = 1'b0;
    if (!rst_n) begin
      m_rd0 = '0; m_rd1 = '0; m_last = 1'b1; m_lock = 0;
      m_ready = cyc + 1; acc_valid = 1'b0; exp_a = '0; exp_wd = '0;
    end else if (acc_valid && cyc == acc_edge + 1) begin
      if (acc_we) model_mem[acc_a[3:0]] = acc_wd;
      else if (acc_port) m_rd1 = model_mem[acc_a[3:0]];
      else m_rd0 = model_mem[acc_a[3:0]];
      if (acc_port) exp_ack1 = 1'b1; else exp_ack0 = 1'b1;
      acc_valid = 1'b0;
    end else if (cyc >= m_ready && (m0_req || m1_req)) begin
      both    = m0_req && m1_req;
      lock_on = m1_lock && m_last && (m_lock < LOCK_MAX);
      if (!both) win = m1_req;
      else if (lock_on) win = 1'b1;
      else win = !m_last;
      if (!win || !m1_lock) m_lock = 0;
      else if (both && lock_on) m_lock++;
      m_last    = win;
      acc_valid = 1'b1;
      acc_edge  = cyc;
      acc_port  = win;
      acc_we    = win ? m1_we : m0_we;
      acc_a     = win ? m1_a : m0_a;
      acc_wd    = win ? m1_wd : m0_wd;
      exp_a     = acc_a;
      exp_wd    = acc_wd;
      exp_we    = acc_we;
      m_ready   = cyc + 3;
    end
    exp_busy = (cyc < m_ready - 1);
  endtask

  task automatic new_req(input bit p, input bit allow_wr);
    logic we;
    we = allow_wr ? 1'($urandom_range(0, 1)) : 1'b0;
    if (!p) begin
      m0_req = 1'b1; m0_we = we; m0_a = AW'($urandom_range(0, 15)); m0_wd = DW'($urandom);
    end else begin
      m1_req = 1'b1; m1_we = we; m1_a = AW'($urandom_range(0, 15)); m1_wd = DW'($urandom);
    end
  endtask

  task automatic drive_next();
    if (exp_ack0) begin
      if (keep_mode) new_req(1'b0, 1'b0);
      else if (rand_mode && $urandom_range(0, 3) != 0) new_req(1'b0, 1'b1);
      else m0_req = 1'b0;
    end else if (rand_mode && !m0_req && $urandom_range(0, 2) == 0) new_req(1'b0, 1'b1);
    if (exp_ack1) begin
      if (keep_mode) new_req(1'b1, 1'b0);
      else if (rand_mode && $urandom_range(0, 3) != 0) new_req(1'b1, 1'b1);
      else m1_req = 1'b0;
    end else if (rand_mode && !m1_req && $urandom_range(0, 2) == 0) new_req(1'b1, 1'b1);
    if (rand_mode) begin
      m1_lock = ($urandom_range(0, 3) != 0);
      rst_n   = ($urandom_range(0, 79) != 0);
    end
  endtask

  // One clock: model the edge just passed, compare every output, then drive the next inputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    model_edge();
    check("m0_ack", m0_ack, exp_ack0);
    check("m1_ack", m1_ack, exp_ack1);
    check("busy", busy, exp_busy);
    check("mem_we", mem_we, exp_we);
    check("mem_a", mem_a, exp_a);
    check("mem_wd", mem_wd, exp_wd);
    check("m0_rd", m0_rd, m_rd0);
    check("m1_rd", m1_rd, m_rd1);
    if (m0_ack) begin
      ack_port.push_back(0); ack_cyc.push_back(cyc);
      $display("txn cyc=%0d port=0 rd=%h", cyc, m0_rd);
    end
    if (m1_ack) begin
      ack_port.push_back(1); ack_cyc.push_back(cyc);
      $display("txn cyc=%0d port=1 rd=%h", cyc, m1_rd);
    end
    drive_next();
  endtask

  task automatic poke(input int a, input logic [DW-1:0] d);
    poke_en = 1'b1; poke_a = 4'(a); poke_d = d; model_mem[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    keep_mode = 1'b0; rand_mode = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    ack_port.delete();
    ack_cyc.delete();
  endtask

  int seq_rr[6]   = '{0, 1, 0, 1, 0, 1};
  int seq_lock[6] = '{1, 1, 1, 1, 0, 1};

  initial begin
    rst_n = 1'b0; m0_req = 1'b0; m0_we = 1'b0; m0_a = '0; m0_wd = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_a = '0; m1_wd = '0; m1_lock = 1'b0;
    for (int i = 0; i < 16; i++) poke(i, init_val(i));

    // Port-0 write then read-back.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_a = AW'(5); m0_wd = DW'(32'hDEADBEEF);
    repeat (3) step();
    check("t1_ack_cyc", ack_cyc.size() > 0 ? ack_cyc[0] : 0, cyc - 1);
    m0_req = 1'b1; m0_we = 1'b0; m0_a = AW'(5);
    repeat (3) step();
    check("t1_rd", m0_rd, DW'(32'hDEADBEEF));

    // Simultaneous first request: port 0 wins the first tie.
    rst_n = 1'b0;
    poke(1, DW'(32'h00020102));
    poke(2, DW'(32'h01030203));
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_a = AW'(1);
    m1_req = 1'b1; m1_we = 1'b0; m1_a = AW'(2);
    repeat (7) step();
    check("t2_first", ack_port.size() > 0 ? ack_port[0] : 9, 0);
    check("t2_gap", ack_cyc.size() > 1 ? ack_cyc[1] - ack_cyc[0] : 0, 3);
    check("t2_rd0", m0_rd, DW'(32'h00020102));
    check("t2_rd1", m1_rd, DW'(32'h01030203));
`ifdef DMEM_ARB_CNT_EN
    check("t2_conflict", cnt_conflict, 1);
`endif

    // Sustained contention without lock alternates.
    do_reset();
    new_req(1'b0, 1'b0); new_req(1'b1, 1'b0);
    keep_mode = 1'b1;
    repeat (18) step();
    keep_mode = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 6; i++)
      check($sformatf("rr_order%0d", i), i < ack_port.size() ? ack_port[i] : 9, seq_rr[i]);

    // Lock bound: four port-1 grants, then port 0, then port 1 again.
    do_reset();
    m1_lock = 1'b1;
    new_req(1'b0, 1'b0); new_req(1'b1, 1'b0);
    keep_mode = 1'b1;
    repeat (18) step();
    keep_mode = 1'b0;
    repeat (6) step();
    m1_lock = 1'b0;
    for (int i = 0; i < 6; i++)
      check($sformatf("lock_order%0d", i), i < ack_port.size() ? ack_port[i] : 9, seq_lock[i]);

    // Reset during ACCESS of a port-1 write drops the write and the ack.
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_a = AW'(3); m1_wd = DW'(32'h12345678);
    step();
    rst_n = 1'b0; m1_req = 1'b0;
    step();
    check("rst_dmem3", dmem[3], init_val(3));
    check("rst_noack", ack_port.size(), 0);
    rst_n = 1'b1;
    repeat (2) step();

    // A port-0 write leaves port-1 read data untouched.
    do_reset();
    m1_req = 1'b1; m1_we = 1'b0; m1_a = AW'(2);
    repeat (3) step();
    m0_req = 1'b1; m0_we = 1'b1; m0_a = AW'(2); m0_wd = DW'(32'hCAFEF00D);
    repeat (3) step();
    check("t6_m1_rd", m1_rd, DW'(32'h01030203));

    // Randomized traffic with locks and sporadic resets.
    do_reset();
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    rst_n = 1'b1;
    repeat (14) step();
    for (int i = 0; i < 16; i++) check($sformatf("mem%0d", i), dmem[i], model_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (16-bit word address, `DATA_W data, combinational read, write on posedge clk) between two requesters.
- Port 0 is the CPU load/store path. Port 1 is a DMA/host loader.
- Sits between both requesters and dmem, drives dmem's a/wd/we, and returns read data with a one-cycle ack pulse.
- Arbitration is round-robin, with an optional bounded lock for port 1 bursts.

Parameters:
- ADDR_W, 16: address width, matches dmem a.
- LOCK_MAX, 4: maximum consecutive port-1 grants while m1_lock is high and m0_req is pending.
- Data width is `DATA_W from def.h, not a parameter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- m0_req  in  1  port 0 access request; held until m0_ack.
- m0_we  in  1  port 0 write enable; 1 = write, 0 = read.
- m0_a  in  ADDR_W  port 0 word address.
- m0_wd  in  `DATA_W  port 0 write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rd  out  `DATA_W  port 0 read data; valid with m0_ack, held until the next port-0 read completes.
- m1_req, m1_we, m1_a, m1_wd, m1_ack, m1_rd: same as port 0, for port 1.
- m1_lock  in  1  port 1 burst lock request.
- mem_a  out  ADDR_W  to dmem a.
- mem_wd  out  `DATA_W  to dmem wd.
- mem_we  out  1  to dmem we.
- mem_rd  in  `DATA_W  from dmem rd (combinational).
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE; mem_a=0, mem_wd=0; m0_ack=m1_ack=0; m0_rd=m1_rd=0.
  - last=1, so port 0 wins the first tie.
  - lock_cnt=0; owner=0.
- mem_we = we_q & (state==ACCESS) & rst_n.
  - A write to dmem happens only at the posedge ending ACCESS.
  - rst_n low during ACCESS suppresses that write.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If either req is high, pick a winner.
  - Capture the winner's a/wd/we into mem_a/mem_wd/we_q; set owner=winner, last=winner; go to ACCESS.
  - With no req, stay in IDLE; mem_a/mem_wd keep their last values.
- Winner selection:
  - Only one requester high: that one wins.
  - Both high, lock active (m1_lock=1, last=1, lock_cnt<LOCK_MAX): port 1 wins and lock_cnt increments.
  - Both high otherwise: the port not equal to last wins.
  - lock_cnt clears whenever port 0 is granted or m1_lock=0 at a grant.
  - If lock_cnt reaches LOCK_MAX with m0_req pending, port 0 wins next.
- ACCESS (one cycle):
  - dmem is driven.
  - If we_q=0, mem_rd is latched into the owner's rd register at the closing edge; go to RESP.
- RESP (one cycle):
  - owner's ack=1; the other ack=0; go to IDLE.
  - req inputs are ignored in RESP.
  - The requester must drop req, or present new a/wd/we, in the cycle after ack.
- Timing:
  - Latency: req seen at posedge N (IDLE) → ack high in cycle N+2.
  - Peak throughput: one access per 3 cycles.
  - A write leaves the owner's rd unchanged.
  - Request signals are sampled only in IDLE; changes during ACCESS/RESP have no effect on the current access.
- Reset mid-operation:
  - Takes effect at the next posedge: state goes to IDLE.
  - A pending ack is not produced; an in-flight write is dropped.
  - The requester re-issues after reset.
- Address wrap: none. The address passes through unmodified; out-of-range is the system's responsibility.

Optional Feature:
- Macro: DMEM_ARB_CNT_EN.
- When defined, the block adds three output ports:
  - cnt_m0 (32): increments on each m0_ack.
  - cnt_m1 (32): increments on each m1_ack.
  - cnt_conflict (32): increments at each IDLE grant where both reqs are high.
- All three clear on reset and wrap modulo 2^32.
- When undefined: no such ports, no counter logic; behaviour is otherwise identical.

Test Plan:
- Reset then port-0 write: m0 write a=5, wd=32'hDEADBEEF. mem_we high exactly one cycle (ACCESS), m0_ack at the cycle-2 edge. A subsequent m0 read of a=5 returns m0_rd=32'hDEADBEEF with ack 2 cycles after req.
- Simultaneous first request: both req at a=1/a=2, both reads, dmem preloaded mem[1]=32'h00020102, mem[2]=32'h01030203. Port 0 is granted first (m0_rd=32'h00020102), then port 1 (m1_rd=32'h01030203). Acks are 3 cycles apart; cnt_conflict=1 if enabled.
- Sustained contention without lock: both req held continuously for 6 accesses. Grants alternate 0,1,0,1,0,1.
- Lock bound: m1_lock=1, both requesting, LOCK_MAX=4, port 1 granted last. Port 1 gets 4 consecutive grants, then port 0 is granted; port 1 resumes after.
- Reset during ACCESS of an m1 write (a=3, wd=32'h12345678): mem[3] is unchanged, no m1_ack, all outputs at reset values the next cycle.
- Read does not disturb: an m0 write completes after a prior m1 read; m1_rd retains its earlier value and the m0 write has no effect on m1_rd.
